lfsr_timer: RTL and testbench

LFSR_TIMER -- requirements
Module: lfsr_timer

---
 rtl/lfsr_pkg.sv | 54 +++++
 rtl/lfsr_step.sv | 18 +
 rtl/lfsr_timer.sv | 115 +++++++++++
 tb/tb_lfsr_timer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR timer.
// Holds the FSM state encoding and the maximal-length tap table (3..32).
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_e;

    localparam int MIN_WIDTH = 3;
    localparam int MAX_WIDTH = 32;

    // Feedback taps for a maximal-period XOR LFSR.
    // Bit i set means register bit i feeds the XOR (stage i+1).
    function automatic logic [31:0] tap_mask(input int width);
        logic [31:0] m;
        case (width)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational next-state of a shift-left Fibonacci XOR LFSR.
// Ports: cur (present state), nxt (state after one step).
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [31:0]      MASK_ALL = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] MASK     = MASK_ALL[WIDTH-1:0];

    // Shift left; parity of the tapped bits enters at bit 0.
    assign nxt = {cur[WIDTH-2:0], ^(cur & MASK)};

endmodule

// File: rtl/lfsr_timer.sv
// lfsr_timer: LFSR-based interval timer with one-shot / auto-reload modes.
// Ports: clk, rst (async, high); start/seed/term/periodic/enable/abort in;
//        busy, done_pulse, done_qo, seed_err, state_qo out.
module lfsr_timer
    import lfsr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit DONE_HOLD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] term,
    input  logic             periodic,
    input  logic             enable,
    input  logic             abort,
    output logic             busy,
    output logic             done_pulse,
    output logic             done_qo,
    output logic             seed_err,
    output logic [WIDTH-1:0] state_qo
);

    timer_state_e     fsm;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] term_q;
    logic             periodic_q;
    logic             done_q;
    logic             hit;
    logic             seed_ok;

    lfsr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .cur(lfsr),
        .nxt(lfsr_nxt)
    );

    // The terminal step is the edge whose *next* state equals term.
    assign hit     = (lfsr_nxt == term_q);
    // An all-zero seed would lock the LFSR forever.
    assign seed_ok = (seed != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= IDLE;
            lfsr       <= '1;
            seed_q     <= '0;
            term_q     <= '0;
            periodic_q <= 1'b0;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
            done_q     <= 1'b0;
            seed_err   <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            seed_err   <= 1'b0;
            if (abort) begin
                // Abort beats start and a coincident terminal step;
                // the LFSR value is left as-is.
                fsm    <= IDLE;
                busy   <= 1'b0;
                done_q <= 1'b0;
            end else begin
                unique case (fsm)
                    IDLE, DONE: begin
                        if (start) begin
                            if (seed_ok) begin
                                seed_q     <= seed;
                                term_q     <= term;
                                periodic_q <= periodic;
                                lfsr       <= seed;
                                fsm        <= RUN;
                                busy       <= 1'b1;
                                done_q     <= 1'b0;
                            end else begin
                                seed_err <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (enable) begin
                            if (hit) begin
                                done_pulse <= 1'b1;
                                done_q     <= 1'b1;
                                if (periodic_q) begin
                                    // Reload the seed so every period
                                    // has the same step count.
                                    lfsr <= seed_q;
                                end else begin
                                    lfsr <= lfsr_nxt;
                                    fsm  <= DONE;
                                    busy <= 1'b0;
                                end
                            end else begin
                                lfsr <= lfsr_nxt;
                            end
                        end
                    end
                    default: begin
                        fsm  <= IDLE;
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_qo = lfsr;
    assign done_qo  = DONE_HOLD ? done_q : done_pulse;

endmodule

// File: tb/tb_lfsr_timer.sv
// tb_lfsr_timer: self-checking bench for lfsr_timer at WIDTH=4.
// Done pulses are scoreboarded against expected cycle numbers.
module tb_lfsr_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] seed;
    logic [W-1:0] term;
    logic         periodic;
    logic         enable;
    logic         abort;
    logic         busy;
    logic         done_pulse;
    logic         done_qo;
    logic         seed_err;
    logic [W-1:0] state_qo;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int exp_done[$];

    lfsr_timer #(
        .WIDTH(W),
        .DONE_HOLD(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .seed(seed),
        .term(term),
        .periodic(periodic),
        .enable(enable),
        .abort(abort),
        .busy(busy),
        .done_pulse(done_pulse),
        .done_qo(done_qo),
        .seed_err(seed_err),
        .state_qo(state_qo)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // x^4 + x^3 + 1, shift left, feedback into bit 0
    function automatic logic [W-1:0] ref_step(input logic [W-1:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    // Scoreboard: every done_pulse must match the oldest expected cycle.
    initial begin : mon
        int e;
        forever begin
            @(negedge clk);
            if (exp_done.size() > 0 && exp_done[0] < cyc) begin
                n_checks++;
                $display("FAIL done_missed: no done_pulse, required at cycle %0d (now %0d)",
                         exp_done[0], cyc);
                void'(exp_done.pop_front());
            end
            if (done_pulse === 1'b1) begin
                n_checks++;
                if (exp_done.size() == 0) begin
                    $display("FAIL done_unexpected: done_pulse=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = exp_done.pop_front();
                    if (cyc !== e)
                        $display("FAIL done_cycle: pulse at %0d, required %0d", cyc, e);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] s,
                            input logic [W-1:0] t,
                            input logic p);
        seed     = s;
        term     = t;
        periodic = p;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        enable = 1'b1; periodic = 1'b0;
        seed = '0; term = '0;
        #2;
        n_checks++;
        if (state_qo !== 4'hF) $display("FAIL rst_state: got %h want f", state_qo);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (done_pulse !== 1'b0) $display("FAIL rst_pulse: got %b want 0", done_pulse);
        else n_pass++;
        n_checks++;
        if (done_qo !== 1'b0) $display("FAIL rst_done_qo: got %b want 0", done_qo);
        else n_pass++;
        n_checks++;
        if (seed_err !== 1'b0) $display("FAIL rst_seed_err: got %b want 0", seed_err);
        else n_pass++;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (state_qo !== 4'hF || busy !== 1'b0 || seed_err !== 1'b0)
            $display("FAIL rst_release: state=%h busy=%b err=%b want f/0/0",
                     state_qo, busy, seed_err);
        else n_pass++;
    endtask

    task automatic test_oneshot();
        logic [W-1:0] m;
        bit run;
        do_start(4'h1, 4'h8, 1'b0);
        exp_done.push_back(cyc + 14);
        n_checks++;
        if (state_qo !== 4'h1 || busy !== 1'b1)
            $display("FAIL os_start: state=%h busy=%b want 1/1", state_qo, busy);
        else n_pass++;
        m = 4'h1; run = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (run) begin
                m = ref_step(m);
                if (m == 4'h8) run = 1'b0;
            end
            n_checks++;
            if (state_qo !== m || busy !== run || done_qo !== (i >= 14))
                $display("FAIL os_step%0d: state=%h busy=%b dq=%b want %h/%b/%b",
                         i, state_qo, busy, done_qo, m, run, (i >= 14));
            else n_pass++;
        end
        n_checks++;
        if (exp_done.size() !== 0)
            $display("FAIL os_pending: %0d pulses outstanding, want 0", exp_done.size());
        else n_pass++;
    endtask

    task automatic test_periodic();
        logic [W-1:0] m;
        int s0;
        do_start(4'h1, 4'h8, 1'b1);
        s0 = cyc;
        exp_done.push_back(s0 + 14);
        exp_done.push_back(s0 + 28);
        exp_done.push_back(s0 + 42);
        n_checks++;
        if (done_qo !== 1'b0) $display("FAIL per_clr_done: got %b want 0", done_qo);
        else n_pass++;
        m = 4'h1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            m = ref_step(m);
            if (m == 4'h8) m = 4'h1;
            n_checks++;
            if (state_qo !== m || busy !== 1'b1)
                $display("FAIL per_step%0d: state=%h busy=%b want %h/1", i, state_qo, busy, m);
            else n_pass++;
        end
        n_checks++;
        if (done_qo !== 1'b1) $display("FAIL per_done_qo: got %b want 1", done_qo);
        else n_pass++;
        do_abort();
        n_checks++;
        if (busy !== 1'b0 || done_qo !== 1'b0 || state_qo !== m)
            $display("FAIL per_abort: busy=%b dq=%b state=%h want 0/0/%h",
                     busy, done_qo, state_qo, m);
        else n_pass++;
        n_checks++;
        if (exp_done.size() !== 0)
            $display("FAIL per_pending: %0d outstanding, want 0", exp_done.size());
        else n_pass++;
    endtask

    task automatic test_enable_gating();
        logic [W-1:0] m;
        bit run;
        enable = 1'b1;
        do_start(4'h1, 4'h8, 1'b0);
        exp_done.push_back(cyc + 28);
        m = 4'h1; run = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            enable = (i % 2 == 0);
            tick();
            if (run && enable) begin
                m = ref_step(m);
                if (m == 4'h8) run = 1'b0;
            end
            n_checks++;
            if (state_qo !== m || busy !== run)
                $display("FAIL gate_step%0d: state=%h busy=%b want %h/%b",
                         i, state_qo, busy, m, run);
            else n_pass++;
        end
        enable = 1'b1;
        n_checks++;
        if (done_qo !== 1'b1 || exp_done.size() !== 0)
            $display("FAIL gate_end: dq=%b pending=%0d want 1/0", done_qo, exp_done.size());
        else n_pass++;
    endtask

    task automatic test_seed_zero();
        logic [W-1:0] m;
        bit run;
        do_abort();
        n_checks++;
        if (done_qo !== 1'b0 || busy !== 1'b0)
            $display("FAIL sz_abort: dq=%b busy=%b want 0/0", done_qo, busy);
        else n_pass++;
        do_start(4'h0, 4'h8, 1'b0);
        n_checks++;
        if (seed_err !== 1'b1 || busy !== 1'b0 || state_qo !== 4'h8)
            $display("FAIL sz_err: err=%b busy=%b state=%h want 1/0/8",
                     seed_err, busy, state_qo);
        else n_pass++;
        tick();
        n_checks++;
        if (seed_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL sz_err_once: err=%b busy=%b want 0/0", seed_err, busy);
        else n_pass++;
        do_start(4'h1, 4'h1, 1'b0);
        exp_done.push_back(cyc + 15);
        m = 4'h1; run = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (run) begin
                m = ref_step(m);
                if (m == 4'h1) run = 1'b0;
            end
            n_checks++;
            if (state_qo !== m || busy !== run)
                $display("FAIL full_step%0d: state=%h busy=%b want %h/%b",
                         i, state_qo, busy, m, run);
            else n_pass++;
        end
        n_checks++;
        if (done_qo !== 1'b1 || exp_done.size() !== 0)
            $display("FAIL full_end: dq=%b pending=%0d want 1/0", done_qo, exp_done.size());
        else n_pass++;
    endtask

    task automatic test_unreachable();
        logic [W-1:0] m;
        do_start(4'h1, 4'h0, 1'b0);
        m = 4'h1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            m = ref_step(m);
        end
        n_checks++;
        if (busy !== 1'b1 || done_qo !== 1'b0 || state_qo !== m)
            $display("FAIL unreach: busy=%b dq=%b state=%h want 1/0/%h",
                     busy, done_qo, state_qo, m);
        else n_pass++;
        do_abort();
    endtask

    task automatic test_abort();
        logic [W-1:0] m;
        do_start(4'h1, 4'h8, 1'b0);
        m = 4'h1;
        for (int i = 1; i <= 13; i++) begin
            if (i == 3) begin
                seed = 4'h5; term = 4'h3; periodic = 1'b1; start = 1'b1;
            end
            tick();
            start = 1'b0;
            m = ref_step(m);
            n_checks++;
            if (state_qo !== m || busy !== 1'b1)
                $display("FAIL ab_step%0d: state=%h busy=%b want %h/1", i, state_qo, busy, m);
            else n_pass++;
        end
        do_abort();
        n_checks++;
        if (state_qo !== 4'hC || busy !== 1'b0 || done_qo !== 1'b0 || done_pulse !== 1'b0)
            $display("FAIL ab_term: state=%h busy=%b dq=%b dp=%b want c/0/0/0",
                     state_qo, busy, done_qo, done_pulse);
        else n_pass++;
        do_start(4'h1, 4'h2, 1'b0);
        exp_done.push_back(cyc + 1);
        tick();
        n_checks++;
        if (done_qo !== 1'b1 || busy !== 1'b0)
            $display("FAIL ab_pre: dq=%b busy=%b want 1/0", done_qo, busy);
        else n_pass++;
        seed = 4'h4; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done_qo !== 1'b0 || state_qo !== 4'h2 || seed_err !== 1'b0)
            $display("FAIL ab_start: busy=%b dq=%b state=%h err=%b want 0/0/2/0",
                     busy, done_qo, state_qo, seed_err);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL ab_idle: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_start(4'h1, 4'h8, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (state_qo !== 4'hF || busy !== 1'b0 || done_qo !== 1'b0)
            $display("FAIL arst: state=%h busy=%b dq=%b want f/0/0",
                     state_qo, busy, done_qo);
        else n_pass++;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (state_qo !== 4'hF || busy !== 1'b0 || exp_done.size() !== 0)
            $display("FAIL arst_release: state=%h busy=%b pending=%0d want f/0/0",
                     state_qo, busy, exp_done.size());
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_enable_gating();
        test_seed_zero();
        test_unreachable();
        test_abort();
        test_async_reset();
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
